// File: rtl/leon_inst_feeder_pkg.sv
// rtl/leon_inst_feeder_pkg.sv - shared types and constants for the LEON instruction feeder
//
// Contents:
//   LEON_NOP        SPARC "sethi 0,%g0" encoding, presented to the core while it is stalled
//   feeder_state_e  feeder FSM states
//   feeder_entry_t  one buffered (pc, inst) pair
package leon_feeder_pkg;

    localparam logic [31:0] LEON_NOP = 32'h0100_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        ERR   = 2'd3
    } feeder_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } feeder_entry_t;

endpackage

// File: rtl/leon_inst_feeder_if.sv
// rtl/leon_inst_feeder_if.sv - driver push channel and core fetch channel of the feeder
//
// Signals:
//   in_valid/in_ready/in_inst/in_pc   driver -> feeder entry push handshake
//   ici_fetch/ici_addr                core fetch strobe and address
//   ico_data/ico_hold                 instruction and run/stall indication to the core
// Modports:
//   master  driver + core side
//   slave   feeder side
interface leon_inst_feeder_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        ici_fetch;
    logic [31:0] ici_addr;
    logic [31:0] ico_data;
    logic        ico_hold;

    modport master (
        output in_valid, in_inst, in_pc, ici_fetch, ici_addr,
        input  in_ready, ico_data, ico_hold
    );

    modport slave (
        input  in_valid, in_inst, in_pc, ici_fetch, ici_addr,
        output in_ready, ico_data, ico_hold
    );

endinterface

// File: rtl/feeder_fifo.sv
// rtl/feeder_fifo.sv - first-word-fall-through FIFO of feeder_entry_t with occupancy
//
// Ports:
//   clk, rst    clock, asynchronous active-low reset (pointers and count only)
//   push        write push_data this cycle (caller guarantees not full)
//   push_data   entry to write
//   pop         drop the head this cycle (caller guarantees not empty)
//   head_nxt    entry that will sit at the head after this clock edge
//   level       current occupancy
//   level_nxt   occupancy after this clock edge
//
// head_nxt lets the owner register the presented instruction without an
// extra cycle of latency after a pop or a push into an empty FIFO.
module feeder_fifo
    import leon_feeder_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  feeder_entry_t          push_data,
    input  logic                   pop,
    output feeder_entry_t          head_nxt,
    output logic [$clog2(DEPTH):0] level,
    output logic [$clog2(DEPTH):0] level_nxt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    feeder_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_nxt;
    logic [LW-1:0] cnt;

    always_comb begin
        rd_ptr_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;

        case ({push, pop})
            2'b10:   level_nxt = cnt + LW'(1);
            2'b01:   level_nxt = cnt - LW'(1);
            default: level_nxt = cnt;
        endcase

        // No older entry survives this edge: the pushed word becomes the head.
        if (push && (cnt == {{AW{1'b0}}, pop})) begin
            head_nxt = push_data;
        end else begin
            head_nxt = mem[rd_ptr_nxt];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_ptr_nxt;
            cnt    <= level_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign level = cnt;

endmodule

// File: rtl/leon_inst_feeder.sv
// rtl/leon_inst_feeder.sv - buffered instruction source driving the LEON icache output port
//
// Ports:
//   clk         core clock
//   rst         asynchronous active-low reset
//   start       single-cycle pulse, leaves IDLE
//   bus         leon_inst_feeder_if.slave: entry push channel, core fetch/ico channel
//   level       FIFO occupancy
//   issued_cnt  instructions consumed by the core (wraps)
//   stall_cnt   fetch cycles spent in STALL (saturates)
//   pc_err      sticky fetch-address mismatch flag
//   err_pc      fetch address captured at the mismatch
//
// Build option LEON_FEEDER_NOP_FILL_EN: when defined, an empty FIFO in RUN
// feeds virtual NOPs with ico_hold=1 instead of stalling the core.
module leon_inst_feeder
    import leon_feeder_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int STALL_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    leon_inst_feeder_if.slave      bus,
    output logic [$clog2(DEPTH):0] level,
    output logic [31:0]            issued_cnt,
    output logic [STALL_W-1:0]     stall_cnt,
    output logic                   pc_err,
    output logic [31:0]            err_pc
);

    localparam int              LW       = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0]   FULL_LVL = LW'(DEPTH);

`ifdef LEON_FEEDER_NOP_FILL_EN
    localparam bit NOP_FILL = 1'b1;
`else
    localparam bit NOP_FILL = 1'b0;
`endif

    feeder_state_e state;
    feeder_state_e state_n;

    logic          in_ready_q;
    logic          ico_hold_q;
    logic [31:0]   ico_data_q;
    // pc of the entry currently at the FIFO head; registered alongside
    // ico_data_q so the fetch check needs no read of the FIFO array.
    logic [31:0]   head_pc_q;

    logic          push;
    logic          pop;
    logic          pc_miss;
    logic          nonempty;
    feeder_entry_t push_entry;
    feeder_entry_t head_nxt;
    logic [LW-1:0] level_nxt;

    assign push            = bus.in_valid && in_ready_q;
    assign nonempty        = (level != '0);
    assign push_entry.pc   = bus.in_pc;
    assign push_entry.inst = bus.in_inst;

    feeder_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_nxt  (head_nxt),
        .level     (level),
        .level_nxt (level_nxt)
    );

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        pc_miss = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n = nonempty ? RUN : STALL;
                end
            end
            RUN: begin
                // An empty FIFO in RUN only happens with NOP fill; the fetch
                // then consumes the virtual NOP and is not checked.
                if (bus.ici_fetch && nonempty) begin
                    if (bus.ici_addr == head_pc_q) begin
                        pop = 1'b1;
                        if (!NOP_FILL && (level == LW'(1)) && !push) begin
                            state_n = STALL;
                        end
                    end else begin
                        pc_miss = 1'b1;
                        state_n = ERR;
                    end
                end
            end
            STALL: begin
                // Uses the registered level, so a push reaches the core two
                // cycles after it is accepted.
                if (nonempty) begin
                    state_n = RUN;
                end
            end
            ERR: begin
                state_n = ERR;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            in_ready_q <= 1'b1;
            ico_hold_q <= 1'b0;
            ico_data_q <= LEON_NOP;
            head_pc_q  <= '0;
            issued_cnt <= '0;
            stall_cnt  <= '0;
            pc_err     <= 1'b0;
            err_pc     <= '0;
        end else begin
            state      <= state_n;
            in_ready_q <= (level_nxt != FULL_LVL);
            ico_hold_q <= (state_n == RUN);
            ico_data_q <= ((state_n == RUN) && (level_nxt != '0)) ? head_nxt.inst : LEON_NOP;
            head_pc_q  <= head_nxt.pc;

            if (pop) begin
                issued_cnt <= issued_cnt + 32'd1;
            end

            if ((state == STALL) && bus.ici_fetch && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + STALL_W'(1);
            end

            if (pc_miss) begin
                pc_err <= 1'b1;
                err_pc <= bus.ici_addr;
            end
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.ico_hold = ico_hold_q;
    assign bus.ico_data = ico_data_q;

endmodule
